fetch_controller: RTL

Sequencing state machine for the instruction-fetch stage. It owns start-up, stall, flush and halt behaviour of the program counter. It drives the PC enable, instruction-request and pipeline-flush controls consumed by the fetch unit and the IF/ID register. It sits between the hazard/branch logic in decode/execute and the fetch stage, replacing the free-running fetch enable.

---
 rtl/control_pkg.sv | 18 +
 rtl/sync_down_counter.sv | 32 +++
 rtl/fetch_controller.sv | 136 +++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared types and constants for the fetch sequencing logic
package control_pkg;

    // Default stall-counter width handed to fetch_controller by its instantiators
    localparam int NOP_CNT_WIDTH = 3;

    // Flush counter only needs to hold FLUSH_DEPTH-1 with FLUSH_DEPTH up to 7
    localparam int FLUSH_CNT_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CPU_GO   = 3'd1,
        FLUSH    = 3'd2,
        STALL    = 3'd3,
        CPU_DONE = 3'd4
    } e_fetch_state;

endpackage

// File: rtl/sync_down_counter.sv
// rtl/sync_down_counter.sv - loadable down counter that saturates at zero
module sync_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;

    // Load wins over decrement; decrement stops at zero so the count never wraps
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - start/stall/flush/halt sequencing for the fetch stage
module fetch_controller
    import control_pkg::*;
#(
    parameter int STALL_CNT_WIDTH = NOP_CNT_WIDTH,
    parameter int FLUSH_DEPTH     = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       stall_set,
    input  logic [STALL_CNT_WIDTH-1:0] stall_count,
    input  logic                       redirect,
    input  logic                       halt_req,
    output logic                       pc_enable,
    output logic                       inst_request,
    output logic                       flush,
    output logic                       cpu_busy,
    output logic                       cpu_done,
    output logic [STALL_CNT_WIDTH-1:0] stall_remaining,
    output logic [2:0]                 state
);

    localparam logic [STALL_CNT_WIDTH-1:0] S_ONE        = STALL_CNT_WIDTH'(1);
    localparam logic [FLUSH_CNT_WIDTH-1:0] F_ONE        = FLUSH_CNT_WIDTH'(1);
    localparam logic [FLUSH_CNT_WIDTH-1:0] FLUSH_RELOAD = FLUSH_CNT_WIDTH'(FLUSH_DEPTH - 1);
    // With a single-cycle flush the redirect cycle itself covers the whole window
    localparam logic                       FLUSH_MULTI  = (FLUSH_DEPTH > 1);

    e_fetch_state state_q, state_d;

    logic                       stall_load;
    logic [STALL_CNT_WIDTH-1:0] stall_load_value;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt;
    logic                       stall_zero;
    logic                       flush_load;
    logic [FLUSH_CNT_WIDTH-1:0] flush_cnt;
    logic                       flush_zero;
    logic [STALL_CNT_WIDTH-1:0] stall_len_m1;
    logic                       stall_last;
    logic                       flush_last;

    // A stall count of zero behaves like one, so the reload value is max(n,1)-1
    assign stall_len_m1 = (stall_count == '0) ? '0 : (stall_count - S_ONE);
    assign stall_last   = stall_zero | (stall_cnt == S_ONE);
    assign flush_last   = flush_zero | (flush_cnt == F_ONE);

    sync_down_counter #(.WIDTH(STALL_CNT_WIDTH)) u_stall_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .load       (stall_load),
        .load_value (stall_load_value),
        .dec        (1'b1),
        .count      (stall_cnt),
        .zero       (stall_zero)
    );

    sync_down_counter #(.WIDTH(FLUSH_CNT_WIDTH)) u_flush_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .load       (flush_load),
        .load_value (FLUSH_RELOAD),
        .dec        (1'b1),
        .count      (flush_cnt),
        .zero       (flush_zero)
    );

    // Next state, counter loads and Mealy controls; halt beats redirect beats stall
    always_comb begin
        state_d          = state_q;
        pc_enable        = 1'b0;
        flush            = 1'b0;
        stall_load       = 1'b0;
        stall_load_value = stall_len_m1;
        flush_load       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CPU_GO;
                end
            end
            CPU_GO, FLUSH, STALL: begin
                if (halt_req) begin
                    state_d = CPU_DONE;
                end else if (redirect) begin
                    pc_enable  = 1'b1;
                    flush      = 1'b1;
                    flush_load = 1'b1;
                    state_d    = FLUSH_MULTI ? FLUSH : CPU_GO;
                    if (state_q == STALL) begin
                        // Redirect abandons any pending stall
                        stall_load       = 1'b1;
                        stall_load_value = '0;
                    end
                end else if (state_q == FLUSH) begin
                    pc_enable = 1'b1;
                    flush     = 1'b1;
                    if (flush_last) begin
                        state_d = CPU_GO;
                    end
                end else if (stall_set) begin
                    stall_load = 1'b1;
                    state_d    = (stall_len_m1 != '0) ? STALL : CPU_GO;
                end else if (state_q == STALL) begin
                    if (stall_last) begin
                        state_d = CPU_GO;
                    end
                end else begin
                    pc_enable = 1'b1;
                end
            end
            CPU_DONE: begin
                state_d = CPU_DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset parks the sequencer in IDLE from any state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign cpu_busy        = (state_q == CPU_GO) || (state_q == FLUSH) || (state_q == STALL);
    assign cpu_done        = (state_q == CPU_DONE);
    assign inst_request    = pc_enable | (redirect & cpu_busy);
    assign stall_remaining = stall_cnt;
    assign state           = state_q;

endmodule
